// File: rtl/usb_tx_pkt_sequencer_if.sv
// Handshake and data bundle between the protocol layer / TX FIFO / bit
// stuffer and the USB full-speed transmit packet sequencer.
interface usb_tx_pkt_sequencer_if;
    logic       tx_start;
    logic [3:0] tx_pid;
    logic [6:0] tx_byte_count;
    logic [7:0] fifo_rdata;
    logic       fifo_empty;
    logic       stuff_hold;
    logic       fifo_re;
    logic       tx_bit;
    logic       tx_bit_valid;
    logic       eop_se0;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    // Environment side: protocol layer, FIFO and stuffer.
    modport master (
        output tx_start, tx_pid, tx_byte_count, fifo_rdata, fifo_empty, stuff_hold,
        input  fifo_re, tx_bit, tx_bit_valid, eop_se0, tx_busy, tx_done, tx_error
    );

    // Sequencer side.
    modport slave (
        input  tx_start, tx_pid, tx_byte_count, fifo_rdata, fifo_empty, stuff_hold,
        output fifo_re, tx_bit, tx_bit_valid, eop_se0, tx_busy, tx_done, tx_error
    );
endinterface

// File: rtl/usb_tx_pkt_sequencer.sv
// USB full-speed transmit packet sequencer: SYNC, PID, payload bytes from the
// TX FIFO, CRC16 and EOP, serialised LSB first with an internal bit timer that
// freezes while the bit stuffer holds the line.
//
// state | meaning
// IDLE  | waiting for tx_start, line idle (J)
// SYNC  | shifting out 0x80 (0000_0001 on the wire)
// PID   | shifting out {~pid, pid}
// DATA  | shifting out a payload byte popped from the FIFO
// CRC1  | shifting out low byte of the complemented CRC
// CRC2  | shifting out high byte of the complemented CRC
// EOP   | two SE0 bit periods followed by one J bit period
module usb_tx_pkt_sequencer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_BYTES    = 64
) (
    input  logic                   clk,
    input  logic                   n_rst,
    usb_tx_pkt_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC1, CRC2, EOP} state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [2:0]       bit_idx_q, bit_idx_n;
    logic [7:0]       shift_q, shift_n;
    logic [15:0]      crc_q, crc_n;
    logic [3:0]       pid_q, pid_n;
    logic [6:0]       rem_q, rem_n;

    logic bit_tick;
    logic want_data;
    logic fifo_re_c;
    logic tx_done_c;
    logic tx_error_c;

    // Reflected CRC-16/USB update with one byte (poly 0xA001).
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    assign bit_tick = (state_q != IDLE) && (cnt_q == CNT_W'(CLKS_PER_BIT)) && !bus.stuff_hold;

    // State register and datapath registers; reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_W'(1);
            bit_idx_q <= '0;
            shift_q   <= '0;
            crc_q     <= 16'hFFFF;
            pid_q     <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            bit_idx_q <= bit_idx_n;
            shift_q   <= shift_n;
            crc_q     <= crc_n;
            pid_q     <= pid_n;
            rem_q     <= rem_n;
        end
    end

    // Next-state, bit timing, byte advance and the single-cycle strobes.
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        bit_idx_n  = bit_idx_q;
        shift_n    = shift_q;
        crc_n      = crc_q;
        pid_n      = pid_q;
        rem_n      = rem_q;
        want_data  = 1'b0;
        fifo_re_c  = 1'b0;
        tx_done_c  = 1'b0;
        tx_error_c = 1'b0;

        if (state_q == IDLE) begin
            if (bus.tx_start) begin
                state_n   = SYNC;
                pid_n     = bus.tx_pid;
                rem_n     = (bus.tx_byte_count > 7'(MAX_BYTES)) ? 7'(MAX_BYTES) : bus.tx_byte_count;
                crc_n     = 16'hFFFF;
                shift_n   = 8'h80;
                cnt_n     = CNT_W'(1);
                bit_idx_n = '0;
            end
        end else if (!bus.stuff_hold) begin
            cnt_n = bit_tick ? CNT_W'(1) : cnt_q + CNT_W'(1);
            if (bit_tick) begin
                shift_n   = shift_q >> 1;
                bit_idx_n = bit_idx_q + 3'd1;
                if (state_q == EOP) begin
                    if (bit_idx_q == 3'd2) begin
                        state_n   = IDLE;
                        bit_idx_n = '0;
                        tx_done_c = 1'b1;
                    end
                end else if (bit_idx_q == 3'd7) begin
                    bit_idx_n = '0;
                    case (state_q)
                        SYNC: begin
                            state_n = PID;
                            shift_n = {~pid_q, pid_q};
                        end
                        PID, DATA: begin
                            if (pid_q[1:0] != 2'b11) begin
                                state_n = EOP;
                            end else if (rem_q != 7'd0) begin
                                want_data = 1'b1;
                            end else begin
                                state_n = CRC1;
                                shift_n = ~crc_q[7:0];
                            end
                        end
                        CRC1: begin
                            state_n = CRC2;
                            shift_n = ~crc_q[15:8];
                        end
                        CRC2: state_n = EOP;
                        default: state_n = state_q;
                    endcase

                    // A missing byte aborts straight to EOP so the receiver
                    // sees a bad packet rather than a truncated CRC.
                    if (want_data) begin
                        if (bus.fifo_empty) begin
                            tx_error_c = 1'b1;
                            state_n    = EOP;
                        end else begin
                            fifo_re_c = 1'b1;
                            state_n   = DATA;
                            shift_n   = bus.fifo_rdata;
                            crc_n     = crc16_byte(crc_q, bus.fifo_rdata);
                            rem_n     = rem_q - 7'd1;
                        end
                    end
                end
            end
        end
    end

    assign bus.fifo_re      = fifo_re_c;
    assign bus.tx_done      = tx_done_c;
    assign bus.tx_error     = tx_error_c;
    assign bus.tx_busy      = (state_q != IDLE);
    assign bus.tx_bit_valid = (state_q != IDLE) && (state_q != EOP);
    assign bus.tx_bit       = bus.tx_bit_valid ? shift_q[0] : 1'b1;
    assign bus.eop_se0      = (state_q == EOP) && (bit_idx_q != 3'd2);
endmodule

// File: tb/tb_usb_tx_pkt_sequencer.sv
// Bench for usb_tx_pkt_sequencer: a packet model expands each request into
// the expected list of bit periods; one negedge process walks that list
// (stretching bits on stuff_hold) and checks every output each cycle.
module tb_usb_tx_pkt_sequencer;
    localparam int CPB  = 8;
    localparam int MAXB = 64;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    usb_tx_pkt_sequencer_if bus();

    usb_tx_pkt_sequencer #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic v;
        logic b;
        logic s;
        logic re;
        logic err;
        logic done;
    } sym_t;

    // Driver-owned model state
    sym_t        exp_arr [0:599];
    int          exp_len = 0;
    int          exp_pops = 0;
    int          exp_err = 0;
    int          pkt_id = 0;
    int          rst_id = 0;
    int          cycle_no = 0;
    int          t_start = 0;
    int          hold_from = 0;
    int          hold_to = 0;
    bit          hold_rand = 0;
    logic [7:0]  fifo_q [$];
    logic [15:0] model_crc_res = 16'h0;
    int          chk_id = 0;
    string       chk_name = "";
    int          chk_lit_cycles = 0;
    int          chk_lit_bits = 0;
    int          chk_lit_pops = -1;
    bit          chk_crc = 0;
    bit          chk_timeout = 0;

    // Compare-owned state
    int pkt_seen = 0, rst_seen = 0, chk_seen = 0;
    bit active = 0;
    int idx = 0, cyc = 0;
    int hold_cnt = 0, re_cnt = 0, err_cnt = 0, done_cnt = 0, done_cycle = 0;
    bit re_seen = 0;
    int n_cmp = 0, n_bad = 0;

    function automatic logic [15:0] crc_model(input logic [15:0] crc_in, input logic [7:0] d);
        logic [15:0] c;
        logic fb;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = c >> 1;
            if (fb) c = c ^ 16'hA001;
        end
        return c;
    endfunction

    function automatic void add_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            exp_arr[exp_len] = '{v: 1'b1, b: b[i], s: 1'b0, re: 1'b0, err: 1'b0, done: 1'b0};
            exp_len++;
        end
    endfunction

    function automatic void build(input logic [3:0] pid, input logic [6:0] cnt);
        int n;
        int k;
        logic [15:0] crc;
        exp_len  = 0;
        exp_pops = 0;
        exp_err  = 0;
        add_byte(8'h80);
        add_byte({~pid, pid});
        if (pid[1:0] == 2'b11) begin
            n = (int'(cnt) > MAXB) ? MAXB : int'(cnt);
            k = (fifo_q.size() < n) ? fifo_q.size() : n;
            crc = 16'hFFFF;
            for (int i = 0; i < k; i++) begin
                exp_arr[exp_len-1].re = 1'b1;
                add_byte(fifo_q[i]);
                crc = crc_model(crc, fifo_q[i]);
            end
            exp_pops = k;
            if (k < n) begin
                exp_arr[exp_len-1].err = 1'b1;
                exp_err = 1;
            end else begin
                add_byte(~crc[7:0]);
                add_byte(~crc[15:8]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            exp_arr[exp_len] = '{v: 1'b0, b: 1'b1, s: (i < 2), re: 1'b0, err: 1'b0, done: (i == 2)};
            exp_len++;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        cycle_no++;
        #1;
        if (re_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        bus.stuff_hold = (hold_rand && active && ($urandom_range(0, 9) == 0)) ||
                         (cycle_no >= hold_from && cycle_no < hold_to);
    endtask

    task automatic fill(input int n, input bit digits);
        for (int i = 0; i < n; i++) begin
            if (digits) fifo_q.push_back(8'h31 + 8'(i));
            else        fifo_q.push_back(8'($urandom));
        end
    endtask

    task automatic start_pkt(input logic [3:0] pid, input logic [6:0] cnt, input bit window);
        build(pid, cnt);
        step();
        bus.tx_start      = 1'b1;
        bus.tx_pid        = pid;
        bus.tx_byte_count = cnt;
        t_start           = cycle_no;
        if (window) begin
            hold_from = cycle_no + 20;
            hold_to   = cycle_no + 23;
        end
        step();
        bus.tx_start      = 1'b0;
        bus.tx_pid        = 4'($urandom);
        bus.tx_byte_count = 7'($urandom);
        pkt_id++;
    endtask

    task automatic finish_pkt(input string name, input int lit_cycles, input int lit_bits,
                              input int lit_pops, input bit crc_pin, input bit poke);
        bit to;
        to = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            step();
            bus.tx_start = (poke && i == 40);
            if (!active) begin
                to = 1'b0;
                break;
            end
        end
        bus.tx_start   = 1'b0;
        chk_name       = name;
        chk_lit_cycles = lit_cycles;
        chk_lit_bits   = lit_bits;
        chk_lit_pops   = lit_pops;
        chk_crc        = crc_pin;
        chk_timeout    = to;
        chk_id++;
        step();
        step();
        fifo_q.delete();
        hold_to = 0;
        step();
    endtask

    function automatic void chk(input string name, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, a, e);
        end
    endfunction

    // Per-cycle compare of every output against the walked model.
    initial begin
        logic [6:0] act;
        logic [6:0] expv;
        sym_t s;
        bit last;
        forever begin
            @(negedge clk);
            if (rst_id != rst_seen) begin
                rst_seen = rst_id;
                active   = 0;
            end
            if (pkt_id != pkt_seen) begin
                pkt_seen = pkt_id;
                active   = 1;
                idx = 0; cyc = 0; hold_cnt = 0; re_cnt = 0; err_cnt = 0; done_cnt = 0; done_cycle = 0;
            end
            re_seen = bus.fifo_re;
            act = {bus.tx_busy, bus.tx_bit_valid, bus.tx_bit, bus.eop_se0, bus.fifo_re, bus.tx_error, bus.tx_done};
            if (!active) begin
                expv = 7'b0010000;
            end else begin
                s    = exp_arr[idx];
                last = (cyc == CPB - 1) && !bus.stuff_hold;
                expv = {1'b1, s.v, s.b, s.s, last & s.re, last & s.err, last & s.done};
                if (bus.fifo_re)  re_cnt++;
                if (bus.tx_error) err_cnt++;
                if (bus.tx_done) begin
                    done_cnt++;
                    done_cycle = cycle_no;
                end
                if (bus.stuff_hold) hold_cnt++;
                else begin
                    cyc++;
                    if (cyc == CPB) begin
                        cyc = 0;
                        idx++;
                        if (idx >= exp_len) active = 0;
                    end
                end
            end
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                if (n_bad < 30)
                    $display("FAIL outputs cycle %0d: got busy,valid,bit,se0,re,err,done=%b want %b",
                             cycle_no, act, expv);
            end
            if (chk_id != chk_seen) begin
                chk_seen = chk_id;
                chk({chk_name, " timeout"}, int'(chk_timeout), 0);
                chk({chk_name, " done_pulses"}, done_cnt, 1);
                chk({chk_name, " fifo_re_pulses"}, re_cnt, exp_pops);
                chk({chk_name, " tx_error_pulses"}, err_cnt, exp_err);
                chk({chk_name, " length"}, done_cycle - t_start, exp_len * CPB + hold_cnt);
                if (chk_lit_cycles > 0) chk({chk_name, " length_lit"}, done_cycle - t_start, chk_lit_cycles);
                if (chk_lit_bits > 0)   chk({chk_name, " model_bits"}, exp_len, chk_lit_bits);
                if (chk_lit_pops >= 0)  chk({chk_name, " pops_lit"}, re_cnt, chk_lit_pops);
                if (chk_crc)            chk({chk_name, " crc_model"}, int'(model_crc_res), 32'hB4C8);
            end
        end
    end

    // Stimulus: directed test-plan packets, mid-packet reset, then random packets.
    initial begin
        logic [15:0] c;
        logic [31:0] rv;
        logic [3:0]  pid;
        logic [6:0]  cnt;
        int          nb;

        n_rst = 1'b0;
        bus.tx_start = 1'b0; bus.tx_pid = '0; bus.tx_byte_count = '0;
        bus.fifo_rdata = '0; bus.fifo_empty = 1'b1; bus.stuff_hold = 1'b0;
        repeat (3) step();
        n_rst = 1'b1;
        repeat (2) step();

        c = 16'hFFFF;
        for (int i = 0; i < 9; i++) c = crc_model(c, 8'h31 + 8'(i));
        model_crc_res = c ^ 16'hFFFF;

        start_pkt(4'b0010, 7'd5, 1'b0);
        finish_pkt("ack", 152, 19, 0, 1'b0, 1'b1);

        fill(9, 1'b1);
        start_pkt(4'b0011, 7'd9, 1'b0);
        finish_pkt("data0_9", 856, 107, 9, 1'b1, 1'b0);

        start_pkt(4'b1011, 7'd0, 1'b0);
        finish_pkt("data1_empty", 280, 35, 0, 1'b0, 1'b0);

        fill(2, 1'b0);
        start_pkt(4'b0011, 7'd4, 1'b0);
        finish_pkt("underrun", 280, 35, 2, 1'b0, 1'b0);

        fill(9, 1'b1);
        start_pkt(4'b0011, 7'd9, 1'b1);
        finish_pkt("hold3", 859, 107, 9, 1'b0, 1'b0);

        fill(20, 1'b0);
        start_pkt(4'b0011, 7'd20, 1'b0);
        repeat (300) step();
        n_rst = 1'b0;
        rst_id++;
        repeat (3) step();
        n_rst = 1'b1;
        fifo_q.delete();
        repeat (2) step();
        fill(3, 1'b0);
        start_pkt(4'b0011, 7'd3, 1'b0);
        finish_pkt("after_reset", 472, 59, 3, 1'b0, 1'b0);

        hold_rand = 1'b1;
        for (int r = 0; r < 12; r++) begin
            rv  = $urandom;
            pid = (rv[3:0] != 4'd0 && rv[3:0] < 4'd12) ? {rv[5:4], 2'b11} : rv[7:4];
            if (r == 3) begin
                cnt = 7'd100;
                nb  = 66;
            end else begin
                cnt = 7'($urandom_range(0, 20));
                nb  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, int'(cnt)) : int'(cnt) + 2;
            end
            fill(nb, 1'b0);
            start_pkt(pid, cnt, 1'b0);
            finish_pkt($sformatf("rand%0d", r), 0, 0, (r == 3 && pid[1:0] == 2'b11) ? 64 : -1,
                       1'b0, r[0]);
        end
        hold_rand = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
